isolde_vli_fetch_buffer: RTL

- Instruction-word prefetch and alignment buffer that sits directly upstream of the ISOLDE custom instruction decoder.
- Accepts a stream of 32-bit words from the instruction fetch path and stores them in a circular buffer.
- Decodes the length of the instruction at the head and presents a 5-word batch window to the decoder.
- Retires a whole variable-length instruction (1-5 words) per consume pulse and supports a pipeline flush.

---
 rtl/isolde_vli_fetch_buffer.sv | 60 ++++++
 1 files changed

// File: rtl/isolde_vli_fetch_buffer.sv
// isolde_vli_fetch_buffer: circular word buffer that decodes the head instruction length
// and presents a 5-word window to the ISOLDE decoder.
module isolde_vli_fetch_buffer #(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  fetch_valid_i,
    output logic                  fetch_ready_o,
    input  logic [31:0]           fetch_rdata_i,
    output logic [4:0][31:0]      batch_o,
    output logic [2:0]            batch_len_o,
    output logic                  batch_valid_o,
    input  logic                  consume_i,
    output logic [CNT_W-1:0]      count_o
);
    localparam int PW = $clog2(DEPTH);
    logic [31:0]      mem [DEPTH];
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [CNT_W-1:0] count;
    logic             push, pop, is_custom;
    logic [2:0]       f3;
    assign fetch_ready_o = count < CNT_W'(DEPTH);
    assign push = fetch_valid_i && fetch_ready_o && !flush_i;
    assign pop = consume_i && batch_valid_o && !flush_i;
    assign count_o = count;
    // Window slots beyond the occupancy read as zero, so an empty buffer decodes as length 1.
    for (genvar i = 0; i < 5; i++) begin : g_win
        assign batch_o[i] = (CNT_W'(i) < count) ? mem[rd_ptr + PW'(i)] : 32'h0;
    end
    always_comb begin
        is_custom = batch_o[0][6:0] == 7'b0001011 || batch_o[0][6:0] == 7'b0101011;
        f3 = batch_o[0][14:12];
        batch_len_o = is_custom ? (f3 > 3'd4 ? 3'd5 : f3 + 3'd1) : 3'd1;
        batch_valid_o = count != '0 && count >= CNT_W'(batch_len_o);
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
            for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= fetch_rdata_i;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + PW'(batch_len_o);
            count <= count + CNT_W'(push) - (pop ? CNT_W'(batch_len_o) : '0);
        end
    end
    assert property (@(posedge clk_i) disable iff (!rst_ni) count <= CNT_W'(DEPTH));
    assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && count == CNT_W'(DEPTH)));
endmodule
